ysyx_23060201_dmem_responder: RTL and testbench

- Memory-side responder for the data-memory request stream produced by the execute stage (write enable/addr/mask/data, read addr/mask).
- Accepts one request at a time over a valid/ready handshake and holds a word-addressed SRAM model.
- Applies byte-lane masks on writes, extracts and zero/sign-extends load data, and returns a response after a programmable latency.
- Replaces the zero-latency combinational `mem_rdata` path, so the core can be moved to a multi-cycle LSU.

---
 rtl/ysyx_23060201_dmem_responder_pkg.sv | 25 ++
 rtl/ysyx_23060201_ld_ext.sv | 26 ++
 rtl/ysyx_23060201_dmem_responder.sv | 141 ++++++++++++++
 tb/tb_ysyx_23060201_dmem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access masks and FSM states.
package ysyx_23060201_dmem_responder_pkg;

    localparam logic [3:0] ysyx_23060201_MASK_B    = 4'b0001;
    localparam logic [3:0] ysyx_23060201_MASK_H    = 4'b0011;
    localparam logic [3:0] ysyx_23060201_MASK_W    = 4'b1111;
    localparam int         ysyx_23060201_MASK_SEXT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Illegal mask encoding or a half/word that is not naturally aligned.
    function automatic logic align_err(input logic [3:0] m, input logic [1:0] off);
        case (m)
            ysyx_23060201_MASK_B: align_err = 1'b0;
            ysyx_23060201_MASK_H: align_err = off[0];
            ysyx_23060201_MASK_W: align_err = (off != 2'd0);
            default:              align_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060201_ld_ext.sv
// Load lane select plus zero/sign extension; shared with the pipelined LSU.
module ysyx_23060201_ld_ext
    import ysyx_23060201_dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [4:0]  rmask,
    output logic [31:0] data
);

    logic [31:0] raw;
    logic        sext;

    assign raw  = word >> {off, 3'b000};
    assign sext = rmask[ysyx_23060201_MASK_SEXT];

    always_comb begin
        data = raw;
        case (rmask[3:0])
            ysyx_23060201_MASK_B: data = {{24{sext & raw[7]}}, raw[7:0]};
            ysyx_23060201_MASK_H: data = {{16{sext & raw[15]}}, raw[15:0]};
            default:              data = raw;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_dmem_responder.sv
// Data-memory responder: one request in flight, word SRAM model, response after LATENCY cycles.
module ysyx_23060201_dmem_responder
    import ysyx_23060201_dmem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [7:0]            req_rmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_wmask;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [4:0]            r_rmask;

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic                  accept, do_access;
    logic                  acc_wen, acc_err;
    logic [ADDR_WIDTH-1:0] acc_addr, rel;
    logic [3:0]            acc_wmask, acc_m, wlanes;
    logic [4:0]            acc_rmask;
    logic [DATA_WIDTH-1:0] acc_wdata, wsh, rd_word, ld_data;
    logic [1:0]            acc_off;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  unused_bits;

    assign unused_bits = ^{req_wmask[7:4], req_rmask[7:5]};

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign do_access  = (accept && LATENCY == 1) || (state == BUSY && cnt == CNT_W'(1));

    // With LATENCY==1 the access happens on the acceptance edge, so use live inputs.
    assign acc_wen   = req_ready ? req_wen        : r_wen;
    assign acc_addr  = req_ready ? req_addr       : r_addr;
    assign acc_wmask = req_ready ? req_wmask[3:0] : r_wmask;
    assign acc_wdata = req_ready ? req_wdata      : r_wdata;
    assign acc_rmask = req_ready ? req_rmask[4:0] : r_rmask;

    assign acc_m   = acc_wen ? acc_wmask : acc_rmask[3:0];
    assign acc_off = acc_addr[1:0];
    assign rel     = acc_addr - BASE_ADDR;
    assign acc_idx = rel[DEPTH_LOG2+1:2];
    assign acc_err = align_err(acc_m, acc_off) || (acc_addr < BASE_ADDR)
                  || ((rel >> (DEPTH_LOG2 + 2)) != '0);
    assign wlanes  = acc_m << acc_off;
    assign wsh     = acc_wdata << {acc_off, 3'b000};
    assign rd_word = mem[acc_idx];

    ysyx_23060201_ld_ext u_ld_ext (
        .word  (rd_word),
        .off   (acc_off),
        .rmask (acc_rmask),
        .data  (ld_data)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 1) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = RESP;
            end
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wmask    <= '0;
            r_wdata    <= '0;
            r_rmask    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                r_wen   <= req_wen;
                r_addr  <= req_addr;
                r_wmask <= req_wmask[3:0];
                r_wdata <= req_wdata;
                r_rmask <= req_rmask[4:0];
            end
            if (do_access) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_wen) ? '0 : ld_data;
            end else if (resp_valid && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_access && acc_wen && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wlanes[i]) mem[acc_idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_dmem_responder.sv
// Directed bench: table of load/store vectors plus backpressure and mid-BUSY reset sequences.
module tb_ysyx_23060201_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wen    [2];
    logic [31:0] req_addr   [2];
    logic [7:0]  req_wmask  [2];
    logic [31:0] req_wdata  [2];
    logic [7:0]  req_rmask  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060201_dmem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wmask(req_wmask[0]), .req_wdata(req_wdata[0]),
        .req_rmask(req_rmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    ysyx_23060201_dmem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wmask(req_wmask[1]), .req_wdata(req_wdata[1]),
        .req_rmask(req_rmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [7:0]  wm;
        logic [31:0] wd;
        logic [7:0]  rm;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction: drive, accept, wait for response, handshake it.
    task automatic xact(input int d, input string nm, input logic wen, input logic [31:0] a,
                        input logic [7:0] wm, input logic [31:0] wd, input logic [7:0] rm,
                        input logic [31:0] erd, input logic eerr);
        int n;
        @(negedge clk);
        req_wen[d] = wen; req_addr[d] = a; req_wmask[d] = wm;
        req_wdata[d] = wd; req_rmask[d] = rm; req_valid[d] = 1'b1;
        chk({nm, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (!resp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), (d == 0) ? 32'd2 : 32'd3);
        chk({nm, "_rdata"}, resp_rdata[d], erd);
        chk({nm, "_err"}, 32'(resp_err[d]), 32'(eerr));
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 8'h00, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h8000_0010, 8'h00, 32'h0,         8'h0F, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h8000_0013, 8'h01, 32'h0000_0080, 8'h00, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 32'h8000_0013, 8'h00, 32'h0,         8'h11, 32'hFFFF_FF80, 1'b0};
        tbl[4]  = '{1'b0, 32'h8000_0013, 8'h00, 32'h0,         8'h01, 32'h0000_0080, 1'b0};
        tbl[5]  = '{1'b0, 32'h8000_0010, 8'h00, 32'h0,         8'h0F, 32'h80AD_BEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h8000_0011, 8'h03, 32'h0000_FFFF, 8'h00, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b0, 32'h8000_0010, 8'h00, 32'h0,         8'h0F, 32'h80AD_BEEF, 1'b0};
        tbl[8]  = '{1'b0, 32'h8000_0012, 8'h00, 32'h0,         8'h0F, 32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b1, 32'h8000_0010, 8'h05, 32'h1111_1111, 8'h00, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 32'h7FFF_FFFC, 8'h00, 32'h0,         8'h0F, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 32'h8000_4000, 8'h00, 32'h0,         8'h0F, 32'h0000_0000, 1'b1};
        tbl[12] = '{1'b0, 32'h8000_0012, 8'h00, 32'h0,         8'h13, 32'hFFFF_80AD, 1'b0};
        tbl[13] = '{1'b0, 32'h8000_0012, 8'h00, 32'h0,         8'h03, 32'h0000_80AD, 1'b0};
        tbl[14] = '{1'b1, 32'h8000_0012, 8'h03, 32'h0000_1234, 8'h00, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b1, 32'h8000_0011, 8'h01, 32'hFFFF_FF7F, 8'h00, 32'h0000_0000, 1'b0};
        tbl[16] = '{1'b0, 32'h8000_0010, 8'h00, 32'h0,         8'h0F, 32'h1234_7FEF, 1'b0};
        tbl[17] = '{1'b1, 32'h8000_3FFC, 8'h0F, 32'hA5A5_0001, 8'h00, 32'h0000_0000, 1'b0};
        tbl[18] = '{1'b0, 32'h8000_3FFE, 8'h00, 32'h0,         8'h13, 32'hFFFF_A5A5, 1'b0};
        tbl[19] = '{1'b0, 32'h8000_3FFC, 8'h00, 32'h0,         8'h11, 32'h0000_0001, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
            req_wmask[d] = '0; req_wdata[d] = '0; req_rmask[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_resp_rdata", resp_rdata[0], 32'd0);
        chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("post_rst_resp_valid", 32'(resp_valid[0]), 32'd0);

        for (int i = 0; i < 20; i++)
            xact(0, $sformatf("vec%0d", i), tbl[i].wen, tbl[i].addr, tbl[i].wm,
                 tbl[i].wd, tbl[i].rm, tbl[i].erd, tbl[i].eerr);

        // Backpressure: response held, stray request during RESP ignored.
        @(negedge clk);
        req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010; req_rmask[0] = 8'h0F; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 1;
        while (!resp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 32'(n), 32'd2);
        req_wen[0] = 1'b1; req_wmask[0] = 8'h0F; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), 32'(resp_valid[0]), 32'd1);
            chk($sformatf("bp_rdata%0d", k), resp_rdata[0], 32'h1234_7FEF);
            chk($sformatf("bp_err%0d", k), 32'(resp_err[0]), 32'd0);
            chk($sformatf("bp_req_ready%0d", k), 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
        @(negedge clk);
        resp_ready[0] = 1'b0;
        chk("bp_after_valid", 32'(resp_valid[0]), 32'd0);
        chk("bp_after_req_ready", 32'(req_ready[0]), 32'd1);
        chk("bp_after_err", 32'(resp_err[0]), 32'd0);
        xact(0, "bp_reload", 1'b0, 32'h8000_0010, 8'h00, 32'h0, 8'h0F, 32'h1234_7FEF, 1'b0);

        // LATENCY=3 instance: reset during BUSY drops the pending store.
        xact(1, "l3_init", 1'b1, 32'h8000_0020, 8'h0F, 32'h0BAD_F00D, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020; req_wmask[1] = 8'h0F;
        req_wdata[1] = 32'h1234_5678; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("l3_busy_req_ready", 32'(req_ready[1]), 32'd0);
        chk("l3_busy_resp_valid", 32'(resp_valid[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("l3_rst_req_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("l3_post_valid%0d", k), 32'(resp_valid[1]), 32'd0);
            chk($sformatf("l3_post_ready%0d", k), 32'(req_ready[1]), 32'd1);
        end
        xact(1, "l3_reload", 1'b0, 32'h8000_0020, 8'h00, 32'h0, 8'h0F, 32'h0BAD_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
